// File: rtl/rns_rev_21_31_32_if.sv
// Handshake bundle for the {21,31,32} RNS-to-binary converter.
// The master drives the residue triple and out_ready; the slave is the converter.
interface rns_rev_21_31_32_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  r21;
  logic [4:0]  r31;
  logic [4:0]  r32;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] x;
  logic        err;

  modport master (
    output in_valid, r21, r31, r32, out_ready,
    input  in_ready, out_valid, x, err
  );

  modport slave (
    input  in_valid, r21, r31, r32, out_ready,
    output in_ready, out_valid, x, err
  );
endinterface

// File: rtl/rns_rev_21_31_32.sv
// Sequential mixed-radix reverse converter for moduli {21,31,32}:
// X = v1 + 21*v2 + 651*v3, one digit per cycle, result held until accepted.
module rns_rev_21_31_32 (
  input  logic                   clk,
  input  logic                   rst,
  rns_rev_21_31_32_if.slave      bus,
  output logic [2:0]             dbg_state
);

  // Handshake: a triple transfers on a rising edge with in_valid & in_ready;
  // a result transfers on a rising edge with out_valid & out_ready, and x/err
  // stay stable while out_valid is high and out_ready is low.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_V2   = 3'd1,
    S_V3   = 3'd2,
    S_SUM  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  r21_q, r21_d;
  logic [4:0]  r31_q, r31_d;
  logic [4:0]  r32_q, r32_d;
  logic        err_in_q, err_in_d;
  logic [4:0]  v2_q, v2_d;
  logic [4:0]  v3_q, v3_d;
  logic [14:0] x_q, x_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;

  logic [6:0]  d_raw, d_red;
  logic [7:0]  t3, t_1;
  logic [4:0]  v2_calc, diff, v3_calc;
  logic [14:0] v1w, v2w, v3w, x_sum;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_V2;
      S_V2:    state_d = S_V3;
      S_V3:    state_d = S_SUM;
      S_SUM:   state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE) && !rst;
    bus.out_valid = out_valid_q;
    bus.x         = x_q;
    bus.err       = err_q;
    dbg_state     = state_q;
  end

  // v1 is the captured r21; v2 is (r31 - v1) * 21^-1 mod 31 with 21^-1 = 3.
  always_comb begin
    d_raw   = 7'(r31_q) + 7'd31 - 7'(r21_q);
    d_red   = (d_raw >= 7'd31) ? d_raw - 7'd31 : d_raw;
    t3      = {d_red, 1'b0} + {1'b0, d_red};
    t_1     = (t3 >= 8'd31) ? t3 - 8'd31 : t3;
    v2_calc = (t_1 >= 8'd31) ? t_1[4:0] - 5'd31 : t_1[4:0];
    diff    = r32_q - r21_q;
    v3_calc = {diff[3:0], 1'b0} + diff + v2_q;
    v1w     = {10'd0, r21_q};
    v2w     = {10'd0, v2_q};
    v3w     = {10'd0, v3_q};
    x_sum   = v1w + (v2w << 4) + (v2w << 2) + v2w
            + (v3w << 9) + (v3w << 7) + (v3w << 3) + (v3w << 1) + v3w;
  end

  always_comb begin
    r21_d       = r21_q;
    r31_d       = r31_q;
    r32_d       = r32_q;
    err_in_d    = err_in_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    x_d         = x_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          r21_d    = bus.r21;
          r31_d    = bus.r31;
          r32_d    = bus.r32;
          err_in_d = (bus.r21 > 5'd20) || (bus.r31 == 5'd31);
        end
      end
      S_V2: v2_d = v2_calc;
      S_V3: v3_d = v3_calc;
      S_SUM: begin
        x_d         = err_in_q ? 15'd0 : x_sum;
        err_d       = err_in_q;
        out_valid_d = 1'b1;
      end
      S_DONE: if (bus.out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r21_q       <= 5'd0;
      r31_q       <= 5'd0;
      r32_q       <= 5'd0;
      err_in_q    <= 1'b0;
      v2_q        <= 5'd0;
      v3_q        <= 5'd0;
      x_q         <= 15'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      r21_q       <= r21_d;
      r31_q       <= r31_d;
      r32_q       <= r32_d;
      err_in_q    <= err_in_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      x_q         <= x_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_rns_rev_21_31_32.sv
// Directed bench for the {21,31,32} reverse converter: reset, known vectors,
// illegal residues, backpressure, mid-conversion reset and a strided sweep.
module tb_rns_rev_21_31_32;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_vec;
  int         n_bad;

  rns_rev_21_31_32_if bus ();

  rns_rev_21_31_32 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_in(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL drive_in_timeout in_ready=%b required=1", bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1;
    bus.r21 = a;
    bus.r31 = b;
    bus.r32 = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.r21 = 5'($urandom_range(0, 31));
    bus.r31 = 5'($urandom_range(0, 31));
    bus.r32 = 5'($urandom_range(0, 31));
  endtask

  // called just after the capture edge; expects out_valid three edges later
  task automatic wait_out(input string name, input logic [14:0] ex, input logic ee);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL %s_latency got=%0d required=3", name, lat);
    end
    n_vec++;
    if (bus.x !== ex) begin
      n_bad++;
      $display("FAIL %s_x got=%0d required=%0d", name, bus.x, ex);
    end
    n_vec++;
    if (bus.err !== ee) begin
      n_bad++;
      $display("FAIL %s_err got=%b required=%b", name, bus.err, ee);
    end
  endtask

  // with out_ready already high, the result leaves on the next edge
  task automatic finish_xfer(input string name);
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_release out_valid=%b in_ready=%b required 0/1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.r21 = 5'd0;
    bus.r31 = 5'd0;
    bus.r32 = 5'd0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.x !== 15'd0 || bus.err !== 1'b0 ||
        bus.in_ready !== 1'b0 || dbg_state !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state out_valid=%b x=%0d err=%b in_ready=%b state=%0d required 0/0/0/0/0",
               bus.out_valid, bus.x, bus.err, bus.in_ready, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
    end
  endtask

  task automatic test_known();
    bus.out_ready = 1'b1;
    drive_in(5'd18, 5'd7, 5'd25);
    wait_out("x12345", 15'd12345, 1'b0);
    finish_xfer("x12345");
  endtask

  task automatic test_boundary();
    logic [4:0]  va[3];
    logic [4:0]  vb[3];
    logic [4:0]  vc[3];
    logic [14:0] vx[3];
    va = '{5'd0, 5'd20, 5'd13};
    vb = '{5'd0, 5'd30, 5'd8};
    vc = '{5'd0, 5'd31, 5'd8};
    vx = '{15'd0, 15'd20831, 15'd1000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(va[i], vb[i], vc[i]);
      wait_out($sformatf("boundary%0d", i), vx[i], 1'b0);
      finish_xfer($sformatf("boundary%0d", i));
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive_in(5'd21, 5'd0, 5'd0);
    wait_out("illegal_r21", 15'd0, 1'b1);
    finish_xfer("illegal_r21");
    drive_in(5'd5, 5'd31, 5'd4);
    wait_out("illegal_r31", 15'd0, 1'b1);
    finish_xfer("illegal_r31");
  endtask

  task automatic test_backpressure();
    int rises;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_in(5'd13, 5'd8, 5'd8);
    wait_out("bp", 15'd1000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.r21 = 5'($urandom_range(0, 31));
      bus.r31 = 5'($urandom_range(0, 31));
      bus.r32 = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.x !== 15'd1000 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d out_valid=%b x=%0d err=%b in_ready=%b required 1/1000/0/0",
                 i, bus.out_valid, bus.x, bus.err, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release out_valid=%b required=0", bus.out_valid);
    end
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) rises++;
    end
    n_vec++;
    if (rises !== 0) begin
      n_bad++;
      $display("FAIL bp_single_transfer extra_valid_cycles=%0d required=0", rises);
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    bus.out_ready = 1'b1;
    drive_in(5'd18, 5'd7, 5'd25);
    @(posedge clk);
    #1;
    n_vec++;
    if (dbg_state !== 3'd2) begin
      n_bad++;
      $display("FAIL rstmid_in_v3 state=%0d required=2", dbg_state);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.x !== 15'd0 || bus.err !== 1'b0 || dbg_state !== 3'd0) begin
      n_bad++;
      $display("FAIL rstmid_cleared out_valid=%b x=%0d err=%b state=%0d required 0/0/0/0",
               bus.out_valid, bus.x, bus.err, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_in_ready got=%b required=1", bus.in_ready);
    end
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) rises++;
    end
    n_vec++;
    if (rises !== 0) begin
      n_bad++;
      $display("FAIL rstmid_no_output valid_cycles=%0d required=0", rises);
    end
    drive_in(5'd18, 5'd7, 5'd25);
    wait_out("rstmid_after", 15'd12345, 1'b0);
    finish_xfer("rstmid_after");
  endtask

  // strided sweep over 0..20831 with random out_ready stalls and a scoreboard
  task automatic test_back_to_back();
    logic [14:0] stim_q[$];
    logic [14:0] exp_q[$];
    logic [14:0] ex;
    int          total;
    int          got;
    int          cyc;
    int          extra;
    for (int v = 0; v <= 20831; v += 7) stim_q.push_back(15'(v));
    stim_q.push_back(15'd20831);
    total = stim_q.size();
    got = 0;
    cyc = 0;
    fork
      begin
        for (int i = 0; i < total; i++) begin
          drive_in(5'(stim_q[i] % 21), 5'(stim_q[i] % 31), 5'(stim_q[i] % 32));
          exp_q.push_back(stim_q[i]);
        end
      end
      begin
        while (got < total && cyc < 40000) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (bus.out_valid && bus.out_ready) begin
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7fff;
            n_vec++;
            if (bus.x !== ex || bus.err !== 1'b0) begin
              n_bad++;
              $display("FAIL sweep_x got=%0d err=%b required=%0d err=0", bus.x, bus.err, ex);
            end
            got++;
          end
          cyc++;
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    n_vec++;
    if (got !== total || exp_q.size() !== 0 || extra !== 0) begin
      n_bad++;
      $display("FAIL sweep_count got=%0d left=%0d extra=%0d required=%0d/0/0",
               got, exp_q.size(), extra, total);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_known();
    test_boundary();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
